// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle ARM-subset datapath.
// Sequences fetch/decode/execute/memory/writeback and adds three things:
// a variable-latency memory handshake with an optional timeout fault,
// a multi-cycle multiply state and an illegal-instruction trap state.
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned TIMEOUT       = 16,
  parameter int unsigned MUL_CYCLES    = 3,
  parameter int unsigned CNT_W         = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       IsMul,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       mul_start,
  output logic       illegal_instr,
  output logic       mem_fault,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StUnknown  = 4'd10,
    StMulEx    = 4'd11,
    StFault    = 4'd12
  } state_e;

  localparam bit             HsEn        = (MEM_HANDSHAKE != 0);
  localparam bit             TimeoutEn   = HsEn && (TIMEOUT != 0);
  // Only meaningful when TimeoutEn is set; a zero TIMEOUT wraps harmlessly.
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MulLast     = CNT_W'(MUL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_fault_q, mem_fault_d;

  logic rdy;
  logic wait_st;
  logic count_st;
  logic timeout;

  // Funct[4:1] belong to the ALU decoder, not to this sequencer.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // With the handshake disabled every memory access completes immediately.
  assign rdy = mem_ready | ~HsEn;

  // Next-state decode, including the memory timeout override.
  always_comb begin
    state_d     = state_q;
    mem_fault_d = mem_fault_q;
    wait_st     = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
    timeout     = TimeoutEn && wait_st && (cnt_q == TimeoutLast) && !rdy;

    case (state_q)
      StFetch:    if (rdy) state_d = StDecode;
      StDecode: begin
        case (Op)
          2'b00: begin
            if (Funct[5])   state_d = StExecuteI;
            else if (IsMul) state_d = StMulEx;
            else            state_d = StExecuteR;
          end
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StUnknown;
        endcase
      end
      StMemAdr:   state_d = Funct[0] ? StMemRead : StMemWrite;
      StMemRead:  if (rdy) state_d = StMemWb;
      StMemWrite: if (rdy) state_d = StFetch;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StMulEx:    if (cnt_q == MulLast) state_d = StAluWb;
      StMemWb:    state_d = StFetch;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StUnknown:  state_d = StFetch;
      StFault:    state_d = StFault;
      default:    state_d = StFetch;
    endcase

    // A completing access on the last allowed cycle never faults.
    if (timeout) begin
      state_d     = StFault;
      mem_fault_d = 1'b1;
    end
  end

  // Wait/multiply counter: cleared on any state change, saturating otherwise.
  always_comb begin
    count_st = wait_st || (state_q == StMulEx);
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (count_st && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, counter and sticky fault registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetch;
      cnt_q       <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  // Moore datapath controls; FETCH strobes are qualified by rdy.
  always_comb begin
    IRWrite       = 1'b0;
    NextPC        = 1'b0;
    AdrSrc        = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ResultSrc     = 2'b00;
    ALUOp         = 1'b0;
    RegW          = 1'b0;
    MemW          = 1'b0;
    Branch        = 1'b0;
    mul_start     = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      StFetch: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = rdy;
        NextPC    = rdy;
      end
      StDecode: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StExecuteR: ALUOp = 1'b1;
      StExecuteI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      StMulEx: begin
        ALUOp     = 1'b1;
        mul_start = (cnt_q == '0);
      end
      StAluWb:  RegW = 1'b1;
      StMemAdr: ALUSrcB = 2'b01;
      StMemRead: AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      StMemWrite: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      StBranch: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      StUnknown: illegal_instr = 1'b1;
      default: ;
    endcase
  end

  assign mem_fault = mem_fault_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. Four instances share the
// stimulus: default parameters, MUL_CYCLES=1, MUL_CYCLES=7, no handshake.
module tb_multicycle_ctrl_fsm;

  localparam logic [3:0] SFetch = 4'd0, SDecode = 4'd1, SMemAdr = 4'd2, SMemRead = 4'd3;
  localparam logic [3:0] SMemWb = 4'd4, SMemWrite = 4'd5, SExecR = 4'd6, SExecI = 4'd7;
  localparam logic [3:0] SAluWb = 4'd8, SBranch = 4'd9, SUnknown = 4'd10, SMulEx = 4'd11;
  localparam logic [3:0] SFault = 4'd12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'b0;
  logic       is_mul = 1'b0;
  logic       mem_ready = 1'b0;

  logic [3:0]      irwrite, nextpc, adrsrc, alusrca, aluop, regw, memw, branch;
  logic [3:0]      mulst, illegal, fault;
  logic [3:0][1:0] alusrcb, resultsrc;
  logic [3:0][3:0] st;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        mr;
    logic        rst;
    logic [3:0]  st;
    logic [13:0] ctl;
    logic        flt;
  } exp_t;

  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm dut0 (
    .clk(clk), .reset(reset), .Op(op), .Funct(funct), .IsMul(is_mul), .mem_ready(mem_ready),
    .IRWrite(irwrite[0]), .NextPC(nextpc[0]), .AdrSrc(adrsrc[0]), .ALUSrcA(alusrca[0]),
    .ALUSrcB(alusrcb[0]), .ResultSrc(resultsrc[0]), .ALUOp(aluop[0]), .RegW(regw[0]),
    .MemW(memw[0]), .Branch(branch[0]), .mul_start(mulst[0]), .illegal_instr(illegal[0]),
    .mem_fault(fault[0]), .state_o(st[0])
  );

  multicycle_ctrl_fsm #(.MUL_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .Op(op), .Funct(funct), .IsMul(is_mul), .mem_ready(mem_ready),
    .IRWrite(irwrite[1]), .NextPC(nextpc[1]), .AdrSrc(adrsrc[1]), .ALUSrcA(alusrca[1]),
    .ALUSrcB(alusrcb[1]), .ResultSrc(resultsrc[1]), .ALUOp(aluop[1]), .RegW(regw[1]),
    .MemW(memw[1]), .Branch(branch[1]), .mul_start(mulst[1]), .illegal_instr(illegal[1]),
    .mem_fault(fault[1]), .state_o(st[1])
  );

  multicycle_ctrl_fsm #(.MUL_CYCLES(7)) dut2 (
    .clk(clk), .reset(reset), .Op(op), .Funct(funct), .IsMul(is_mul), .mem_ready(mem_ready),
    .IRWrite(irwrite[2]), .NextPC(nextpc[2]), .AdrSrc(adrsrc[2]), .ALUSrcA(alusrca[2]),
    .ALUSrcB(alusrcb[2]), .ResultSrc(resultsrc[2]), .ALUOp(aluop[2]), .RegW(regw[2]),
    .MemW(memw[2]), .Branch(branch[2]), .mul_start(mulst[2]), .illegal_instr(illegal[2]),
    .mem_fault(fault[2]), .state_o(st[2])
  );

  multicycle_ctrl_fsm #(.MEM_HANDSHAKE(0)) dut3 (
    .clk(clk), .reset(reset), .Op(op), .Funct(funct), .IsMul(is_mul), .mem_ready(mem_ready),
    .IRWrite(irwrite[3]), .NextPC(nextpc[3]), .AdrSrc(adrsrc[3]), .ALUSrcA(alusrca[3]),
    .ALUSrcB(alusrcb[3]), .ResultSrc(resultsrc[3]), .ALUOp(aluop[3]), .RegW(regw[3]),
    .MemW(memw[3]), .Branch(branch[3]), .mul_start(mulst[3]), .illegal_instr(illegal[3]),
    .mem_fault(fault[3]), .state_o(st[3])
  );

  // Control word packing:
  // {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,RegW,MemW,Branch,mul_start,illegal}
  function automatic logic [13:0] act_ctl(input int k);
    return {irwrite[k], nextpc[k], adrsrc[k], alusrca[k], alusrcb[k], resultsrc[k],
            aluop[k], regw[k], memw[k], branch[k], mulst[k], illegal[k]};
  endfunction

  // Reference control table, written from the state/output list.
  function automatic logic [13:0] exp_ctl(input logic [3:0] s, input logic rdy,
                                          input logic first);
    logic irw, npc, adr, sa, ao, rw, mw, br, ms, il;
    logic [1:0] sb, rs;
    {irw, npc, adr, sa, ao, rw, mw, br, ms, il} = '0;
    sb = 2'b00;
    rs = 2'b00;
    case (s)
      SFetch:    begin sa = 1; sb = 2'b10; rs = 2'b10; irw = rdy; npc = rdy; end
      SDecode:   begin sa = 1; sb = 2'b10; rs = 2'b10; end
      SMemAdr:   sb = 2'b01;
      SMemRead:  adr = 1;
      SMemWb:    begin rs = 2'b01; rw = 1; end
      SMemWrite: begin adr = 1; mw = 1; end
      SExecR:    ao = 1;
      SExecI:    begin sb = 2'b01; ao = 1; end
      SAluWb:    rw = 1;
      SBranch:   begin sb = 2'b01; rs = 2'b10; br = 1; end
      SUnknown:  il = 1;
      SMulEx:    begin ao = 1; ms = first; end
      default:   ;
    endcase
    return {irw, npc, adr, sa, sb, rs, ao, rw, mw, br, ms, il};
  endfunction

  // mr: mem_ready driven that cycle; er: effective rdy seen by the design.
  task automatic push(input logic mr, input logic rs, input logic [3:0] s, input logic er,
                      input logic first, input logic flt);
    exp_t n;
    n.mr  = mr;
    n.rst = rs;
    n.st  = s;
    n.ctl = exp_ctl(s, er, first);
    n.flt = flt;
    q.push_back(n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (st[0] !== SFetch || fault[0] !== 1'b0 || act_ctl(0) !== exp_ctl(SFetch, 1'b1, 1'b0))
      begin
      bad++;
      $display("FAIL reset_rdy1: got st=%0d ctl=%h flt=%b want st=0 ctl=%h flt=0",
               st[0], act_ctl(0), fault[0], exp_ctl(SFetch, 1'b1, 1'b0));
    end
    mem_ready = 1'b0;
    #1;
    total++;
    if (st[0] !== SFetch || irwrite[0] !== 1'b0 || nextpc[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_rdy0: got st=%0d irw=%b npc=%b want st=0 irw=0 npc=0",
               st[0], irwrite[0], nextpc[0]);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_alu();
    for (int v = 0; v < 2; v++) begin
      do_reset();
      op = 2'b00;
      is_mul = 1'b0;
      funct = (v == 0) ? 6'b001000 : 6'b101000;
      push(1, 0, SFetch, 1, 0, 0);
      push(0, 0, SDecode, 0, 0, 0);
      push(0, 0, (v == 0) ? SExecR : SExecI, 0, 0, 0);
      push(0, 0, SAluWb, 0, 0, 0);
      push(0, 0, SFetch, 0, 0, 0);
      while (q.size() != 0) begin
        e = q.pop_front();
        mem_ready = e.mr;
        reset = e.rst;
        #1;
        total++;
        if (st[0] !== e.st || act_ctl(0) !== e.ctl || fault[0] !== e.flt) begin
          bad++;
          $display("FAIL alu%0d: got st=%0d ctl=%h flt=%b want st=%0d ctl=%h flt=%b", v,
                   st[0], act_ctl(0), fault[0], e.st, e.ctl, e.flt);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_load_stall();
    do_reset();
    op = 2'b01;
    funct = 6'b000001;
    is_mul = 1'b0;
    push(1, 0, SFetch, 1, 0, 0);
    push(0, 0, SDecode, 0, 0, 0);
    push(0, 0, SMemAdr, 0, 0, 0);
    for (int i = 0; i < 3; i++) push(0, 0, SMemRead, 0, 0, 0);
    push(1, 0, SMemRead, 1, 0, 0);
    push(0, 0, SMemWb, 0, 0, 0);
    push(0, 0, SFetch, 0, 0, 0);
    while (q.size() != 0) begin
      e = q.pop_front();
      mem_ready = e.mr;
      reset = e.rst;
      #1;
      total++;
      if (st[0] !== e.st || act_ctl(0) !== e.ctl || fault[0] !== e.flt) begin
        bad++;
        $display("FAIL ldr_stall: got st=%0d ctl=%h flt=%b want st=%0d ctl=%h flt=%b",
                 st[0], act_ctl(0), fault[0], e.st, e.ctl, e.flt);
      end
      @(negedge clk);
    end
  endtask

  // Store timeout into FAULT, recovery by reset, then a reset mid-MEMWRITE.
  task automatic test_store_timeout();
    do_reset();
    op = 2'b01;
    funct = 6'b000000;
    is_mul = 1'b0;
    push(1, 0, SFetch, 1, 0, 0);
    push(0, 0, SDecode, 0, 0, 0);
    push(0, 0, SMemAdr, 0, 0, 0);
    for (int i = 0; i < 16; i++) push(0, 0, SMemWrite, 0, 0, 0);
    for (int i = 0; i < 3; i++) push(1, 0, SFault, 1, 0, 1);
    push(0, 1, SFault, 0, 0, 1);
    push(0, 0, SFetch, 0, 0, 0);
    push(1, 0, SFetch, 1, 0, 0);
    push(0, 0, SDecode, 0, 0, 0);
    push(0, 0, SMemAdr, 0, 0, 0);
    push(0, 0, SMemWrite, 0, 0, 0);
    push(0, 1, SMemWrite, 0, 0, 0);
    push(0, 0, SFetch, 0, 0, 0);
    push(0, 0, SFetch, 0, 0, 0);
    while (q.size() != 0) begin
      e = q.pop_front();
      mem_ready = e.mr;
      reset = e.rst;
      #1;
      total++;
      if (st[0] !== e.st || act_ctl(0) !== e.ctl || fault[0] !== e.flt) begin
        bad++;
        $display("FAIL str_timeout: got st=%0d ctl=%h flt=%b want st=%0d ctl=%h flt=%b",
                 st[0], act_ctl(0), fault[0], e.st, e.ctl, e.flt);
      end
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  task automatic test_mul();
    int n;
    for (int k = 0; k < 3; k++) begin
      n = (k == 0) ? 3 : (k == 1) ? 1 : 7;
      do_reset();
      op = 2'b00;
      funct = 6'b000000;
      is_mul = 1'b1;
      push(1, 0, SFetch, 1, 0, 0);
      push(0, 0, SDecode, 0, 0, 0);
      for (int i = 0; i < n; i++) push(0, 0, SMulEx, 0, (i == 0), 0);
      push(0, 0, SAluWb, 0, 0, 0);
      push(0, 0, SFetch, 0, 0, 0);
      while (q.size() != 0) begin
        e = q.pop_front();
        mem_ready = e.mr;
        reset = e.rst;
        #1;
        total++;
        if (st[k] !== e.st || act_ctl(k) !== e.ctl || fault[k] !== e.flt) begin
          bad++;
          $display("FAIL mul_n%0d: got st=%0d ctl=%h flt=%b want st=%0d ctl=%h flt=%b", n,
                   st[k], act_ctl(k), fault[k], e.st, e.ctl, e.flt);
        end
        @(negedge clk);
      end
    end
    is_mul = 1'b0;
  endtask

  task automatic test_branch_unknown();
    for (int v = 0; v < 2; v++) begin
      do_reset();
      op = (v == 0) ? 2'b11 : 2'b10;
      funct = 6'b000000;
      push(1, 0, SFetch, 1, 0, 0);
      push(0, 0, SDecode, 0, 0, 0);
      push(0, 0, (v == 0) ? SUnknown : SBranch, 0, 0, 0);
      push(0, 0, SFetch, 0, 0, 0);
      while (q.size() != 0) begin
        e = q.pop_front();
        mem_ready = e.mr;
        reset = e.rst;
        #1;
        total++;
        if (st[0] !== e.st || act_ctl(0) !== e.ctl || fault[0] !== e.flt) begin
          bad++;
          $display("FAIL %s: got st=%0d ctl=%h flt=%b want st=%0d ctl=%h flt=%b",
                   (v == 0) ? "unknown" : "branch", st[0], act_ctl(0), fault[0], e.st,
                   e.ctl, e.flt);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_no_handshake();
    do_reset();
    op = 2'b01;
    funct = 6'b000001;
    push(0, 0, SFetch, 1, 0, 0);
    push(0, 0, SDecode, 1, 0, 0);
    push(0, 0, SMemAdr, 1, 0, 0);
    push(0, 0, SMemRead, 1, 0, 0);
    push(0, 0, SMemWb, 1, 0, 0);
    push(0, 0, SFetch, 1, 0, 0);
    while (q.size() != 0) begin
      e = q.pop_front();
      mem_ready = e.mr;
      reset = e.rst;
      #1;
      total++;
      if (st[3] !== e.st || act_ctl(3) !== e.ctl || fault[3] !== e.flt) begin
        bad++;
        $display("FAIL no_hs: got st=%0d ctl=%h flt=%b want st=%0d ctl=%h flt=%b",
                 st[3], act_ctl(3), fault[3], e.st, e.ctl, e.flt);
      end
      @(negedge clk);
    end
  endtask

  // Completion on the very cycle the timeout would fire must win.
  task automatic test_timeout_boundary();
    do_reset();
    op = 2'b01;
    funct = 6'b000001;
    push(1, 0, SFetch, 1, 0, 0);
    push(0, 0, SDecode, 0, 0, 0);
    push(0, 0, SMemAdr, 0, 0, 0);
    for (int i = 0; i < 15; i++) push(0, 0, SMemRead, 0, 0, 0);
    push(1, 0, SMemRead, 1, 0, 0);
    push(0, 0, SMemWb, 0, 0, 0);
    push(0, 0, SFetch, 0, 0, 0);
    while (q.size() != 0) begin
      e = q.pop_front();
      mem_ready = e.mr;
      reset = e.rst;
      #1;
      total++;
      if (st[0] !== e.st || act_ctl(0) !== e.ctl || fault[0] !== e.flt) begin
        bad++;
        $display("FAIL to_boundary: got st=%0d ctl=%h flt=%b want st=%0d ctl=%h flt=%b",
                 st[0], act_ctl(0), fault[0], e.st, e.ctl, e.flt);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_stall();
    test_store_timeout();
    test_mul();
    test_branch_unknown();
    test_no_handshake();
    test_timeout_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
